flags_register: RTL

- Holds the five ALU status flags between the execute stage and the branch/condition logic. It sits directly downstream of the ALU.
- Latches the ALU flag outputs when an ALU op retires. Feeds the registered logic carry back to the ALU as its carry input.
- Saves/restores flags over MainBus for interrupt/push/pop.
- Evaluates 4-bit branch condition codes with a one-cycle registered result and same-cycle flag forwarding.

---
 rtl/flags_register.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/flags_register.sv
// flags_register: ALU status flag store sitting between execute and the
// branch/condition logic.
//
// Flag bit map: 0 Overflow, 1 Sign, 2 Zero, 3 CarryA, 4 CarryL.
//
// Ports
//   Clock          in     rising-edge clock for all state
//   Reset          in     synchronous, active-high; overrides all other inputs
//   MainBus        inout  8-bit shared bus; driven only while Flags_Assert=1
//   AluFlags       in     flag outputs of the ALU
//   Flags_Load     in     latch AluFlags on this edge
//   Flags_BusLoad  in     latch MainBus[4:0] on this edge (restore)
//   Flags_Assert   in     drive {3'b000, Flags} onto MainBus (combinational)
//   Cond_Valid     in     evaluate Cond_Code this cycle
//   Cond_Code      in     4-bit condition select
//   Flags          out    registered flag state
//   LCarry_Out     out    Flags[4], fed back to the ALU carry input
//   ACarry_Out     out    Flags[3]
//   Cond_Done      out    one-cycle strobe, condition result valid
//   Cond_Taken     out    registered condition result, held until next Cond_Done
//   Load_Conflict  out    sticky: BusLoad and Load collided; cleared by Reset only
module flags_register #(
  parameter int unsigned FLAG_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  inout  wire  [7:0]        MainBus,
  input  logic [FLAG_W-1:0] AluFlags,
  input  logic              Flags_Load,
  input  logic              Flags_BusLoad,
  input  logic              Flags_Assert,
  input  logic              Cond_Valid,
  input  logic [3:0]        Cond_Code,
  output logic [FLAG_W-1:0] Flags,
  output logic              LCarry_Out,
  output logic              ACarry_Out,
  output logic              Cond_Done,
  output logic              Cond_Taken,
  output logic              Load_Conflict
);

  localparam int unsigned BUS_W  = 8;
  localparam int unsigned PAD_W  = BUS_W - FLAG_W;
  localparam int unsigned BIT_O  = 0;
  localparam int unsigned BIT_S  = 1;
  localparam int unsigned BIT_Z  = 2;
  localparam int unsigned BIT_CA = 3;
  localparam int unsigned BIT_CL = 4;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              cond_done_q, cond_done_d;
  logic              cond_taken_q, cond_taken_d;
  logic              conflict_q, conflict_d;

  logic [FLAG_W-1:0] src_flags_c;
  logic              cond_hit_c;
  logic              f_o, f_s, f_z, f_ca, f_cl;
  logic              signed_lt_c;

  // Upper bus bits are never loaded into the flags.
  logic unused_bus_hi;
  assign unused_bus_hi = ^MainBus[BUS_W-1:FLAG_W];

  // Bus driver: only while asserted, otherwise released.
  assign MainBus = Flags_Assert ? {PAD_W'(1'b0), flags_q} : {BUS_W{1'bz}};

  // Forward ALU flags into the condition unit when they retire this cycle
  // without being overridden by a bus restore; the bus value is never forwarded.
  always_comb begin
    src_flags_c = flags_q;
    if (Flags_Load && !Flags_BusLoad) begin
      src_flags_c = AluFlags;
    end
  end

  assign f_o         = src_flags_c[BIT_O];
  assign f_s         = src_flags_c[BIT_S];
  assign f_z         = src_flags_c[BIT_Z];
  assign f_ca        = src_flags_c[BIT_CA];
  assign f_cl        = src_flags_c[BIT_CL];
  assign signed_lt_c = f_s ^ f_o;

  // Condition code decode.
  always_comb begin
    cond_hit_c = 1'b0;
    case (Cond_Code)
      4'd0:  cond_hit_c = f_o;
      4'd1:  cond_hit_c = !f_o;
      4'd2:  cond_hit_c = f_s;
      4'd3:  cond_hit_c = !f_s;
      4'd4:  cond_hit_c = f_z;
      4'd5:  cond_hit_c = !f_z;
      4'd6:  cond_hit_c = f_ca;
      4'd7:  cond_hit_c = !f_ca;
      4'd8:  cond_hit_c = f_cl;
      4'd9:  cond_hit_c = !f_cl;
      4'd10: cond_hit_c = f_ca && !f_z;
      4'd11: cond_hit_c = !f_ca || f_z;
      4'd12: cond_hit_c = signed_lt_c;
      4'd13: cond_hit_c = !signed_lt_c;
      4'd14: cond_hit_c = !f_z && !signed_lt_c;
      4'd15: cond_hit_c = f_z || signed_lt_c;
    endcase
  end

  // Next-state: bus restore beats ALU load; a collision is remembered.
  always_comb begin
    flags_d      = flags_q;
    conflict_d   = conflict_q;
    cond_done_d  = 1'b0;
    cond_taken_d = cond_taken_q;

    if (Flags_BusLoad) begin
      flags_d = MainBus[FLAG_W-1:0];
    end else if (Flags_Load) begin
      flags_d = AluFlags;
    end

    if (Flags_BusLoad && Flags_Load) begin
      conflict_d = 1'b1;
    end

    if (Cond_Valid) begin
      cond_done_d  = 1'b1;
      cond_taken_d = cond_hit_c;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      flags_q      <= '0;
      cond_done_q  <= 1'b0;
      cond_taken_q <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      cond_done_q  <= cond_done_d;
      cond_taken_q <= cond_taken_d;
      conflict_q   <= conflict_d;
    end
  end

  assign Flags         = flags_q;
  assign LCarry_Out    = flags_q[BIT_CL];
  assign ACarry_Out    = flags_q[BIT_CA];
  assign Cond_Done     = cond_done_q;
  assign Cond_Taken    = cond_taken_q;
  assign Load_Conflict = conflict_q;

endmodule
